// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit: holds HI/LO and models mult/div latency with a
// countdown while the 64-bit result waits in pending registers.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [3:0] MULT_LAT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LAT  = 4'(DIV_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic        pend_wr_q, pend_wr_d;

  // Multiplication: both products are exact in 64 bits.
  logic [63:0] a_sext, b_sext, prod_s, prod_u;
  assign a_sext = {{32{A[31]}}, A};
  assign b_sext = {{32{B[31]}}, B};
  assign prod_s = a_sext * b_sext;
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Signed division via magnitudes so 0x80000000 / -1 wraps to 0x80000000
  // without relying on simulator behaviour for signed overflow.
  logic        b_zero;
  logic [31:0] a_mag, b_mag, b_mag_safe, b_safe;
  logic [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;
  assign b_zero     = (B == 32'd0);
  assign a_mag      = A[31] ? (~A + 32'd1) : A;
  assign b_mag      = B[31] ? (~B + 32'd1) : B;
  assign b_mag_safe = b_zero ? 32'd1 : b_mag;
  assign b_safe     = b_zero ? 32'd1 : B;
  assign q_mag      = a_mag / b_mag_safe;
  assign r_mag      = a_mag % b_mag_safe;
  assign q_s        = (A[31] ^ B[31]) ? (~q_mag + 32'd1) : q_mag;
  assign r_s        = A[31] ? (~r_mag + 32'd1) : r_mag;
  assign q_u        = A / b_safe;
  assign r_u        = A % b_safe;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (md_op)
            OP_MULT: begin
              pend_hi_d = prod_s[63:32];
              pend_lo_d = prod_s[31:0];
              pend_wr_d = 1'b1;
              cnt_d     = MULT_LAT;
              state_d   = RUN;
            end
            OP_MULTU: begin
              pend_hi_d = prod_u[63:32];
              pend_lo_d = prod_u[31:0];
              pend_wr_d = 1'b1;
              cnt_d     = MULT_LAT;
              state_d   = RUN;
            end
            OP_DIV: begin
              pend_hi_d = r_s;
              pend_lo_d = q_s;
              pend_wr_d = ~b_zero;
              cnt_d     = DIV_LAT;
              state_d   = RUN;
            end
            OP_DIVU: begin
              pend_hi_d = r_u;
              pend_lo_d = q_u;
              pend_wr_d = ~b_zero;
              cnt_d     = DIV_LAT;
              state_d   = RUN;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      RUN: begin
        // Any start seen here is ignored; the counter alone ends the run.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = IDLE;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  assign busy = (state_q == RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit: latency, HI/LO results, reset abort,
// divide-by-zero, mthi/mtlo and ignored mid-run starts.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int vectors_applied = 0;
  int miscompares     = 0;

  mult_div_unit #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .md_op(md_op),
    .A    (a),
    .B    (b),
    .busy (busy),
    .hi   (hi),
    .lo   (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors_applied++;
    if (observed !== expected) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end else begin
      $display("ok   %s: 0x%08h", tag, observed);
    end
  endtask

  // Drive one start pulse; returns 1ns after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
    start = 1'b1;
    md_op = op;
    a     = av;
    b     = bv;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Walk an operation of latency lat: busy high and HI/LO held for lat cycles,
  // then busy low. Optionally injects an mtlo start at offset inject_at.
  task automatic wait_op(input string tag, input int lat, input logic [31:0] old_hi,
                         input logic [31:0] old_lo, input int inject_at);
    for (int k = 0; k < lat; k++) begin
      check($sformatf("%s busy@%0d", tag, k), {31'd0, busy}, 32'd1);
      check($sformatf("%s hi_hold@%0d", tag, k), hi, old_hi);
      check($sformatf("%s lo_hold@%0d", tag, k), lo, old_lo);
      if (k == inject_at) begin
        start = 1'b1;
        md_op = 3'd5;
        a     = 32'hDEAD_BEEF;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    check($sformatf("%s busy_done", tag), {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    md_op = 3'd0;
    a     = 32'd0;
    b     = 32'd0;
    #1;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // mult -3 * 5 = -15
    issue(3'd0, 32'hFFFF_FFFD, 32'd5);
    wait_op("mult", 5, 32'd0, 32'd0, -1);
    check("mult hi", hi, 32'hFFFF_FFFF);
    check("mult lo", lo, 32'hFFFF_FFF1);

    // Same mult aborted by asynchronous reset after edge 2
    issue(3'd0, 32'hFFFF_FFFD, 32'd5);
    @(posedge clk);
    #1;
    check("abort busy_pre", {31'd0, busy}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort hi", hi, 32'd0);
    check("abort lo", lo, 32'd0);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("abort idle busy@%0d", k), {31'd0, busy}, 32'd0);
      check($sformatf("abort idle lo@%0d", k), lo, 32'd0);
    end

    // multu 0xFFFFFFFF * 2
    issue(3'd1, 32'hFFFF_FFFF, 32'd2);
    wait_op("multu", 5, 32'd0, 32'd0, -1);
    check("multu hi", hi, 32'h0000_0001);
    check("multu lo", lo, 32'hFFFF_FFFE);

    // div -7 / 2 -> q=-3, r=-1
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_op("div", 10, 32'h0000_0001, 32'hFFFF_FFFE, -1);
    check("div hi", hi, 32'hFFFF_FFFF);
    check("div lo", lo, 32'hFFFF_FFFD);

    // div overflow 0x80000000 / -1
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_op("divovf", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, -1);
    check("divovf hi", hi, 32'd0);
    check("divovf lo", lo, 32'h8000_0000);

    // mthi / mtlo preload, no busy
    issue(3'd4, 32'h0000_1234, 32'd0);
    check("mthi busy", {31'd0, busy}, 32'd0);
    check("mthi hi", hi, 32'h0000_1234);
    check("mthi lo", lo, 32'h8000_0000);
    issue(3'd5, 32'h0000_5678, 32'd0);
    check("mtlo busy", {31'd0, busy}, 32'd0);
    check("mtlo lo", lo, 32'h0000_5678);

    // reserved md_op is a no-op
    issue(3'd6, 32'hAAAA_AAAA, 32'h1);
    check("rsvd busy", {31'd0, busy}, 32'd0);
    check("rsvd hi", hi, 32'h0000_1234);
    check("rsvd lo", lo, 32'h0000_5678);

    // divu by zero: full latency, HI/LO untouched
    issue(3'd3, 32'd7, 32'd0);
    wait_op("divz", 10, 32'h0000_1234, 32'h0000_5678, -1);
    check("divz hi", hi, 32'h0000_1234);
    check("divz lo", lo, 32'h0000_5678);

    // Back-to-back mult then divu; mtlo pulse mid-divu is ignored
    issue(3'd0, 32'd2, 32'd3);
    wait_op("b2b mult", 5, 32'h0000_1234, 32'h0000_5678, -1);
    check("b2b mult hi", hi, 32'd0);
    check("b2b mult lo", lo, 32'd6);
    issue(3'd3, 32'd100, 32'd7);
    wait_op("b2b divu", 10, 32'd0, 32'd6, 3);
    check("b2b divu hi", hi, 32'd2);
    check("b2b divu lo", lo, 32'd14);
    @(posedge clk);
    #1;
    check("b2b after lo", lo, 32'd14);
    check("b2b after busy", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
